// File: rtl/scanner_link_tx.sv
// scanner_link_tx
//   Transmit end of the scanner-to-transfer-center serial link. Bits leave MSB
//   first, one per clk, in 8-bit frames aligned to a free-running slot counter.
//   Frames carry command codes 1..8, the data byte that follows code 7/8, or
//   0x00 when there is nothing to send.
//
// Ports
//   clk         clock, all state changes on posedge
//   rst         asynchronous active-low reset
//   bufLevel    local buffer occupancy, 0..DEPTH (above DEPTH counts as full)
//   flushReq    1-cycle pulse, queue code 5
//   readyReq    1-cycle pulse, queue code 6
//   txReq       level, data byte waiting; held until txAck
//   txAscii     with txReq: 1 = code 8, 0 = code 7
//   txData      data byte, captured on the txAck cycle
//   dataOut     serial line (MSB of the shift register)
//   frameStart  high while slot 0 is on dataOut
//   txAck       1-cycle pulse in slot 7 when txData/txAscii are captured
//   busy        high while the frame on the line is not an idle frame
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | idle frame (0x00) on the line
// S_CMD        | status/flush/ready command frame on the line
// S_DATA_NEXT  | code 7/8 on the line, data byte goes out next frame
// S_DATA       | data byte on the line

module scanner_link_tx #(
  parameter int CNT_W = 5,
  parameter int DEPTH = 20,
  parameter int TH50  = 10,
  parameter int TH80  = 16,
  parameter int TH90  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] bufLevel,
  input  logic             flushReq,
  input  logic             readyReq,
  input  logic             txReq,
  input  logic             txAscii,
  input  logic [7:0]       txData,
  output logic             dataOut,
  output logic             frameStart,
  output logic             txAck,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA_NEXT, S_DATA} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TH50_C  = CNT_W'(TH50);
  localparam logic [CNT_W-1:0] TH80_C  = CNT_W'(TH80);
  localparam logic [CNT_W-1:0] TH90_C  = CNT_W'(TH90);

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic [2:0] band_q, band_d;
  logic [2:0] stat_code_q, stat_code_d;
  logic       stat_pend_q, stat_pend_d;
  logic       flush_pend_q, flush_pend_d;
  logic       ready_pend_q, ready_pend_d;

  logic [2:0] band_now;
  logic       load_stat, load_flush, load_ready;

  // Levels at or above DEPTH all land in the "full" band.
  always_comb begin
    band_now = 3'd0;
    if (bufLevel >= DEPTH_C)     band_now = 3'd4;
    else if (bufLevel >= TH90_C) band_now = 3'd3;
    else if (bufLevel >= TH80_C) band_now = 3'd2;
    else if (bufLevel >= TH50_C) band_now = 3'd1;
  end

  always_comb begin
    slot_d     = slot_q + 3'd1;
    shreg_d    = {shreg_q[6:0], 1'b0};
    state_d    = state_q;
    data_d     = data_q;
    txAck      = 1'b0;
    load_stat  = 1'b0;
    load_flush = 1'b0;
    load_ready = 1'b0;

    if (slot_q == 3'd7) begin
      if (state_q == S_DATA_NEXT) begin
        shreg_d = data_q;
        state_d = S_DATA;
      end else if (stat_pend_q) begin
        shreg_d   = {5'b0, stat_code_q};
        state_d   = S_CMD;
        load_stat = 1'b1;
      end else if (flush_pend_q) begin
        shreg_d    = 8'h05;
        state_d    = S_CMD;
        load_flush = 1'b1;
      end else if (ready_pend_q) begin
        shreg_d    = 8'h06;
        state_d    = S_CMD;
        load_ready = 1'b1;
      end else if (txReq) begin
        shreg_d = txAscii ? 8'h08 : 8'h07;
        data_d  = txData;
        txAck   = 1'b1;
        state_d = S_DATA_NEXT;
      end else begin
        shreg_d = 8'h00;
        state_d = S_IDLE;
      end
    end

    // Clears come from the load above; a set arriving on the same edge wins.
    band_d      = band_now;
    stat_pend_d = stat_pend_q & ~load_stat;
    stat_code_d = stat_code_q;
    if (band_now > band_q) begin
      stat_pend_d = 1'b1;
      stat_code_d = band_now;
    end
    flush_pend_d = flushReq | (flush_pend_q & ~load_flush);
    ready_pend_d = readyReq | (ready_pend_q & ~load_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      slot_q       <= 3'd0;
      shreg_q      <= 8'h00;
      data_q       <= 8'h00;
      band_q       <= 3'd0;
      stat_code_q  <= 3'd0;
      stat_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      ready_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      band_q       <= band_d;
      stat_code_q  <= stat_code_d;
      stat_pend_q  <= stat_pend_d;
      flush_pend_q <= flush_pend_d;
      ready_pend_q <= ready_pend_d;
    end
  end

  assign dataOut    = shreg_q[7];
  assign frameStart = (slot_q == 3'd0);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_scanner_link_tx.sv
// tb_scanner_link_tx
//   Directed scenarios checked against hand-built frame sequences, plus a long
//   randomized run checked against a frame-level reference model (a queue of
//   frames still to send and plain pending flags).

module tb_scanner_link_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] bufLevel = '0;
  logic       flushReq = 1'b0;
  logic       readyReq = 1'b0;
  logic       txReq = 1'b0;
  logic       txAscii = 1'b0;
  logic [7:0] txData = '0;
  logic       dataOut, frameStart, txAck, busy;

  int tests = 0;
  int fails = 0;

  scanner_link_tx dut (
    .clk(clk), .rst(rst), .bufLevel(bufLevel), .flushReq(flushReq),
    .readyReq(readyReq), .txReq(txReq), .txAscii(txAscii), .txData(txData),
    .dataOut(dataOut), .frameStart(frameStart), .txAck(txAck), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  logic [7:0] m_cur;
  bit         m_cur_busy;
  int         m_pos;
  logic [7:0] m_q[$];
  bit         m_stat, m_flush, m_ready;
  int         m_code, m_band;

  function automatic int band_of(int lvl);
    if (lvl >= 20) return 4;
    if (lvl >= 18) return 3;
    if (lvl >= 16) return 2;
    if (lvl >= 10) return 1;
    return 0;
  endfunction

  function automatic bit m_ack_now();
    return (m_pos == 7) && (m_q.size() == 0) && !m_stat && !m_flush && !m_ready && txReq;
  endfunction

  task automatic model_reset();
    m_cur = 8'h00; m_cur_busy = 0; m_pos = 0; m_q.delete();
    m_stat = 0; m_flush = 0; m_ready = 0; m_code = 0; m_band = 0;
  endtask

  task automatic model_edge();
    int nb;
    if (m_pos == 7) begin
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front(); m_cur_busy = 1;
      end else if (m_stat) begin
        m_cur = 8'(m_code); m_cur_busy = 1; m_stat = 0;
      end else if (m_flush) begin
        m_cur = 8'h05; m_cur_busy = 1; m_flush = 0;
      end else if (m_ready) begin
        m_cur = 8'h06; m_cur_busy = 1; m_ready = 0;
      end else if (txReq) begin
        m_cur = txAscii ? 8'h08 : 8'h07; m_cur_busy = 1; m_q.push_back(txData);
      end else begin
        m_cur = 8'h00; m_cur_busy = 0;
      end
    end
    nb = band_of(int'(bufLevel));
    if (nb > m_band) begin m_stat = 1; m_code = nb; end
    m_band = nb;
    if (flushReq) m_flush = 1;
    if (readyReq) m_ready = 1;
    m_pos = (m_pos + 1) % 8;
  endtask

  // Sample outputs (1 ns after the inputs were set at negedge), predict them,
  // advance the model over the coming posedge, and move to the next negedge.
  // obs/exp packing: {dataOut, frameStart, txAck, busy}.
  task automatic tick(output logic [3:0] obs, output logic [3:0] exp);
    #1;
    obs = {dataOut, frameStart, txAck, busy};
    exp = {m_cur[7-m_pos], (m_pos == 0), m_ack_now(), m_cur_busy};
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [3:0] dexp(logic [7:0] fb, int k, int ack_k, bit bz);
    return {fb[7 - (k % 8)], (k % 8) == 0, k == ack_k, bz};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bufLevel = '0; flushReq = 0; readyReq = 0; txReq = 0; txAscii = 0; txData = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] obs, exp;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({dataOut, frameStart, txAck, busy} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_state got=%b want=0100", {dataOut, frameStart, txAck, busy});
    end
    do_reset();
    for (int k = 0; k < 32; k++) begin
      tick(obs, exp);
      tests++;
      if (obs !== dexp(8'h00, k, -1, 0)) begin
        fails++;
        $display("FAIL idle_k%0d got=%b want=%b", k, obs, dexp(8'h00, k, -1, 0));
      end
    end
  endtask

  task automatic test_tx_binary();
    logic [3:0] obs, exp, want;
    logic [7:0] fr[4];
    fr = '{8'h00, 8'h07, 8'hA5, 8'h00};
    do_reset();
    txReq = 1; txAscii = 0; txData = 8'hA5;
    for (int k = 0; k < 32; k++) begin
      tick(obs, exp);
      if (k == 7) begin txReq = 0; txData = 8'h00; end
      want = dexp(fr[k/8], k, 7, (k >= 8 && k < 24));
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL tx_bin_k%0d got=%b want=%b", k, obs, want);
      end
    end
  endtask

  task automatic test_band();
    logic [3:0] obs, exp, want;
    logic [7:0] fr[5];
    fr = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00};
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (k == 1)  bufLevel = 5'd10;
      if (k == 3)  bufLevel = 5'd16;
      if (k == 10) bufLevel = 5'd5;
      if (k == 18) bufLevel = 5'd10;
      tick(obs, exp);
      want = dexp(fr[k/8], k, -1, (k/8 == 1) || (k/8 == 3));
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL band_k%0d got=%b want=%b", k, obs, want);
      end
    end
  endtask

  task automatic test_multi_req();
    logic [3:0] obs, exp, want;
    logic [7:0] fr[6];
    fr = '{8'h00, 8'h05, 8'h06, 8'h07, 8'h3C, 8'h00};
    do_reset();
    for (int k = 0; k < 48; k++) begin
      flushReq = (k == 1);
      readyReq = (k == 2);
      if (k == 3) begin txReq = 1; txAscii = 0; txData = 8'h3C; end
      tick(obs, exp);
      if (k == 23) txReq = 0;
      want = dexp(fr[k/8], k, 23, (k >= 8 && k < 40));
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL multi_k%0d got=%b want=%b", k, obs, want);
      end
    end
    flushReq = 0; readyReq = 0;
  endtask

  task automatic test_status_after_data();
    logic [3:0] obs, exp, want;
    logic [7:0] fr[5];
    fr = '{8'h00, 8'h08, 8'h5A, 8'h04, 8'h00};
    do_reset();
    txReq = 1; txAscii = 1; txData = 8'h5A;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) bufLevel = 5'd20;
      tick(obs, exp);
      if (k == 7) begin txReq = 0; txAscii = 0; end
      want = dexp(fr[k/8], k, 7, (k >= 8 && k < 32));
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL stat_after_data_k%0d got=%b want=%b", k, obs, want);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] obs, exp;
    do_reset();
    txReq = 1; txData = 8'hFF;
    for (int k = 0; k < 19; k++) begin
      tick(obs, exp);
      if (k == 7) txReq = 0;
    end
    // cycle 19 = slot 3 of the 0xFF data frame
    #1;
    tests++;
    if ({dataOut, busy} !== 2'b11) begin
      fails++;
      $display("FAIL midframe_pre got=%b want=11", {dataOut, busy});
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({dataOut, frameStart, txAck, busy} !== 4'b0100) begin
      fails++;
      $display("FAIL midframe_rst got=%b want=0100", {dataOut, frameStart, txAck, busy});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(obs, exp);
      tests++;
      if (obs !== dexp(8'h00, k, -1, 0)) begin
        fails++;
        $display("FAIL after_rst_k%0d got=%b want=%b", k, obs, dexp(8'h00, k, -1, 0));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] obs, exp;
    bit active;
    do_reset();
    active = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) bufLevel = 5'($urandom_range(0, 31));
      flushReq = ($urandom_range(0, 40) == 0);
      readyReq = ($urandom_range(0, 40) == 0);
      if (!active && $urandom_range(0, 10) == 0) begin
        active = 1; txAscii = 1'($urandom_range(0, 1));
      end else if (active && $urandom_range(0, 60) == 0) begin
        active = 0;
      end
      txReq = active;
      txData = 8'($urandom_range(0, 255));
      tick(obs, exp);
      if (exp[1]) active = 0;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random_k%0d got=%b want=%b", k, obs, exp);
      end
    end
    flushReq = 0; readyReq = 0; txReq = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tx_binary();
    test_band();
    test_multi_req();
    test_status_after_data();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
